// File: rtl/sha256_pkg.sv
// Shared constants, state encoding and helpers for the SHA-256 message padder.
package sha256_pkg;

  localparam int unsigned WORD_W    = 32;
  localparam int unsigned BLK_WORDS = 16;
  localparam int unsigned BLK_W     = WORD_W * BLK_WORDS;
  localparam int unsigned LEN_IDX   = 14;
  localparam int unsigned IDX_W     = 5;

  localparam logic [WORD_W-1:0] PAD_WORD = 32'h8000_0000;
  localparam logic [IDX_W-1:0]  IDX_FULL = IDX_W'(BLK_WORDS);
  localparam logic [IDX_W-1:0]  IDX_LEN  = IDX_W'(LEN_IDX);

  localparam logic [1:0] ST_IDLE_ENC = 2'd0;
  localparam logic [1:0] ST_FILL_ENC = 2'd1;
  localparam logic [1:0] ST_PAD_ENC  = 2'd2;
  localparam logic [1:0] ST_EMIT_ENC = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = ST_IDLE_ENC,
    ST_FILL = ST_FILL_ENC,
    ST_PAD  = ST_PAD_ENC,
    ST_EMIT = ST_EMIT_ENC
  } state_t;

  // Reverse byte order of a 32-bit word.
  function automatic logic [WORD_W-1:0] bswap32(input logic [WORD_W-1:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

// File: rtl/sha256_pad_word.sv
// Masks a big-endian final word to its valid bytes and inserts the 0x80 marker after them.
module sha256_pad_word
  import sha256_pkg::*;
(
  input  logic [WORD_W-1:0] data,
  input  logic [2:0]        nbytes,
  output logic [WORD_W-1:0] padded_c
);

  always_comb begin
    padded_c = data;
    case (nbytes)
      3'd0:    padded_c = PAD_WORD;
      3'd1:    padded_c = {data[31:24], 24'h80_0000};
      3'd2:    padded_c = {data[31:16], 16'h8000};
      3'd3:    padded_c = {data[31:8],  8'h80};
      default: padded_c = data;
    endcase
  end

endmodule

// File: rtl/sha256_msg_padder.sv
// SHA-256 message padder: packs 32-bit words into 512-bit blocks, appends 0x80,
// zero fill and the 64-bit message bit length.
module sha256_msg_padder
  import sha256_pkg::*;
#(
  parameter int unsigned CNT_W     = 64,
  parameter bit          BYTE_SWAP = 1'b0
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_last,
  input  logic [2:0]        in_nbytes,
  output logic              blk_valid,
  input  logic              blk_ready,
  output logic [BLK_W-1:0]  blk_data,
  output logic              blk_first,
  output logic              blk_final,
  output logic              busy
);

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]   bitcnt_q, bitcnt_d;
  logic [WORD_W-1:0]  blk_buf_q [BLK_WORDS];
  logic [WORD_W-1:0]  blk_buf_d [BLK_WORDS];
  logic               need_mark_q, need_mark_d;
  logic               ret_pad_q, ret_pad_d;
  logic               first_q, first_d;
  logic               final_q, final_d;

  logic [WORD_W-1:0]  in_word;
  logic [WORD_W-1:0]  padded_c;
  logic [63:0]        len64;

  assign in_word = BYTE_SWAP ? bswap32(in_data) : in_data;
  assign len64   = 64'(bitcnt_q);

  sha256_pad_word u_pad_word (
    .data     (in_word),
    .nbytes   (in_nbytes),
    .padded_c (padded_c)
  );

  for (genvar i = 0; i < BLK_WORDS; i++) begin : g_blk_out
    assign blk_data[BLK_W-1-WORD_W*i -: WORD_W] = blk_buf_q[i];
  end

  // Next-state, buffer writes and counters.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    bitcnt_d    = bitcnt_q;
    blk_buf_d   = blk_buf_q;
    need_mark_d = need_mark_q;
    ret_pad_d   = ret_pad_q;
    first_d     = first_q;
    final_d     = final_q;
    case (state_q)
      ST_IDLE, ST_FILL: begin
        if (in_valid) begin
          blk_buf_d[idx_q[IDX_W-2:0]] = in_last ? padded_c : in_word;
          idx_d     = idx_q + IDX_W'(1);
          bitcnt_d  = bitcnt_q + CNT_W'({in_nbytes, 3'b000});
          ret_pad_d = in_last;
          final_d   = 1'b0;
          if (state_q == ST_IDLE) first_d = 1'b1;
          if (in_last) need_mark_d = (in_nbytes == 3'd4);
          if (idx_d == IDX_FULL) state_d = ST_EMIT;
          else if (in_last)      state_d = ST_PAD;
          else                   state_d = ST_FILL;
        end
      end
      ST_PAD: begin
        idx_d     = idx_q + IDX_W'(1);
        ret_pad_d = 1'b1;
        final_d   = 1'b0;
        if (need_mark_q) begin
          blk_buf_d[idx_q[IDX_W-2:0]] = PAD_WORD;
          need_mark_d = 1'b0;
        end else if (idx_q == IDX_LEN) begin
          // Length only fits when two slots remain; otherwise zero-fill and spill.
          blk_buf_d[LEN_IDX]     = len64[63:32];
          blk_buf_d[LEN_IDX + 1] = len64[31:0];
          idx_d   = IDX_FULL;
          final_d = 1'b1;
        end else begin
          blk_buf_d[idx_q[IDX_W-2:0]] = '0;
        end
        if (idx_d == IDX_FULL) state_d = ST_EMIT;
      end
      ST_EMIT: begin
        if (blk_ready) begin
          idx_d   = '0;
          first_d = 1'b0;
          if (final_q) begin
            state_d  = ST_IDLE;
            bitcnt_d = '0;
          end else begin
            state_d = ret_pad_q ? ST_PAD : ST_FILL;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, datapath and registered outputs.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      bitcnt_q    <= '0;
      need_mark_q <= 1'b0;
      ret_pad_q   <= 1'b0;
      first_q     <= 1'b0;
      final_q     <= 1'b0;
      for (int i = 0; i < BLK_WORDS; i++) blk_buf_q[i] <= '0;
      in_ready    <= 1'b1;
      blk_valid   <= 1'b0;
      blk_first   <= 1'b0;
      blk_final   <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      bitcnt_q    <= bitcnt_d;
      need_mark_q <= need_mark_d;
      ret_pad_q   <= ret_pad_d;
      first_q     <= first_d;
      final_q     <= final_d;
      for (int i = 0; i < BLK_WORDS; i++) blk_buf_q[i] <= blk_buf_d[i];
      in_ready    <= (state_d == ST_IDLE) || (state_d == ST_FILL);
      blk_valid   <= (state_d == ST_EMIT);
      blk_first   <= (state_d == ST_EMIT) && first_d;
      blk_final   <= (state_d == ST_EMIT) && final_d;
      busy        <= (state_d != ST_IDLE);
    end
  end

endmodule

// File: tb/tb_sha256_msg_padder.sv
// Directed bench for sha256_msg_padder: known padding vectors, back-pressure and reset.
module tb_sha256_msg_padder;

  logic         wb_clk_i;
  logic         wb_rst_i;
  logic         in_valid;
  logic         in_ready;
  logic [31:0]  in_data;
  logic         in_last;
  logic [2:0]   in_nbytes;
  logic         blk_valid;
  logic         blk_ready;
  logic [511:0] blk_data;
  logic         blk_first;
  logic         blk_final;
  logic         busy;

  int checks = 0;
  int errors = 0;

  sha256_msg_padder #(.CNT_W(64), .BYTE_SWAP(1'b0)) dut (
    .wb_clk_i  (wb_clk_i),
    .wb_rst_i  (wb_rst_i),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_nbytes (in_nbytes),
    .blk_valid (blk_valid),
    .blk_ready (blk_ready),
    .blk_data  (blk_data),
    .blk_first (blk_first),
    .blk_final (blk_final),
    .busy      (busy)
  );

  initial wb_clk_i = 1'b0;
  always #5 wb_clk_i = ~wb_clk_i;

  // Message byte n has value n; word i holds bytes 4i..4i+3.
  function automatic logic [31:0] pat(input int i);
    return {8'(4*i), 8'(4*i+1), 8'(4*i+2), 8'(4*i+3)};
  endfunction

  task automatic send_word(input logic [31:0] d, input logic [2:0] nb, input logic last);
    int n = 0;
    @(negedge wb_clk_i);
    in_valid = 1'b1; in_data = d; in_nbytes = nb; in_last = last;
    while (!in_ready && n < 100) begin
      @(negedge wb_clk_i);
      n++;
    end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL send_timeout: in_ready=%0b, required 1", in_ready);
    end
    @(posedge wb_clk_i); #1;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic get_block(input int stall, output logic [511:0] d, output logic f, output logic l);
    int n = 0;
    @(negedge wb_clk_i);
    while (!blk_valid && n < 300) begin
      @(negedge wb_clk_i);
      n++;
    end
    checks++;
    if (blk_valid !== 1'b1) begin
      errors++;
      $display("FAIL blk_valid_timeout: blk_valid=%0b, required 1", blk_valid);
    end
    d = blk_data; f = blk_first; l = blk_final;
    for (int c = 0; c < stall; c++) begin
      @(negedge wb_clk_i);
      checks++;
      if (blk_data !== d || blk_valid !== 1'b1 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold cycle %0d: valid=%0b in_ready=%0b data_changed=%0b, required 1/0/0",
                 c, blk_valid, in_ready, blk_data !== d);
      end
    end
    blk_ready = 1'b1;
    @(posedge wb_clk_i); #1;
    blk_ready = 1'b0;
    @(negedge wb_clk_i);
    checks++;
    if (blk_valid !== 1'b0) begin
      errors++;
      $display("FAIL blk_valid_drop: blk_valid=%0b, required 0", blk_valid);
    end
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (in_ready !== 1'b1 || blk_valid !== 1'b0 || blk_first !== 1'b0 ||
        blk_final !== 1'b0 || busy !== 1'b0 || blk_data !== 512'd0) begin
      errors++;
      $display("FAIL reset_outputs: in_ready=%0b valid=%0b first=%0b final=%0b busy=%0b data=%h, required 1/0/0/0/0/0",
               in_ready, blk_valid, blk_first, blk_final, busy, blk_data);
    end
    repeat (3) @(negedge wb_clk_i);
    wb_rst_i = 1'b0;
  endtask

  task automatic test_abc();
    logic [511:0] d, exp;
    logic f, l;
    exp = '0;
    exp[511:480] = 32'h6162_6380;
    exp[31:0]    = 32'h18;
    send_word(32'h6162_6300, 3'd3, 1'b1);
    @(negedge wb_clk_i);
    checks++;
    if (in_ready !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL abc_pad_busy: in_ready=%0b busy=%0b, required 0/1", in_ready, busy);
    end
    get_block(0, d, f, l);
    checks++;
    if (d !== exp) begin
      errors++;
      $display("FAIL abc_data: got %h required %h", d, exp);
    end
    checks++;
    if (f !== 1'b1 || l !== 1'b1) begin
      errors++;
      $display("FAIL abc_flags: first=%0b final=%0b, required 1/1", f, l);
    end
    checks++;
    if (busy !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL abc_idle: busy=%0b in_ready=%0b, required 0/1", busy, in_ready);
    end
  endtask

  task automatic test_empty();
    logic [511:0] d, exp;
    logic f, l;
    exp = '0;
    exp[511:480] = 32'h8000_0000;
    send_word(32'hDEAD_BEEF, 3'd0, 1'b1);
    get_block(0, d, f, l);
    checks++;
    if (d !== exp || f !== 1'b1 || l !== 1'b1) begin
      errors++;
      $display("FAIL empty_block: got %h f=%0b l=%0b required %h f=1 l=1", d, f, l, exp);
    end
  endtask

  task automatic test_55_bytes();
    logic [511:0] d, exp;
    logic f, l;
    exp = '0;
    for (int i = 0; i < 13; i++) begin
      send_word(pat(i), 3'd4, 1'b0);
      exp[511-32*i -: 32] = pat(i);
    end
    send_word(32'h3435_36FF, 3'd3, 1'b1);
    exp[511-32*13 -: 32] = 32'h3435_3680;
    exp[31:0] = 32'h1B8;
    get_block(0, d, f, l);
    checks++;
    if (d !== exp || f !== 1'b1 || l !== 1'b1) begin
      errors++;
      $display("FAIL b55_block: got %h f=%0b l=%0b required %h f=1 l=1", d, f, l, exp);
    end
  endtask

  task automatic test_56_bytes();
    logic [511:0] d, exp;
    logic f, l;
    exp = '0;
    for (int i = 0; i < 14; i++) begin
      send_word(pat(i), 3'd4, i == 13);
      exp[511-32*i -: 32] = pat(i);
    end
    exp[63:32] = 32'h8000_0000;
    get_block(0, d, f, l);
    checks++;
    if (d !== exp || f !== 1'b1 || l !== 1'b0) begin
      errors++;
      $display("FAIL b56_blk1: got %h f=%0b l=%0b required %h f=1 l=0", d, f, l, exp);
    end
    exp = '0;
    exp[31:0] = 32'h1C0;
    get_block(0, d, f, l);
    checks++;
    if (d !== exp || f !== 1'b0 || l !== 1'b1) begin
      errors++;
      $display("FAIL b56_blk2: got %h f=%0b l=%0b required %h f=0 l=1", d, f, l, exp);
    end
  endtask

  task automatic test_64_bytes_stall();
    logic [511:0] d, exp;
    logic f, l;
    exp = '0;
    for (int i = 0; i < 16; i++) begin
      send_word(pat(i), 3'd4, i == 15);
      exp[511-32*i -: 32] = pat(i);
    end
    get_block(10, d, f, l);
    checks++;
    if (d !== exp || f !== 1'b1 || l !== 1'b0) begin
      errors++;
      $display("FAIL b64_blk1: got %h f=%0b l=%0b required %h f=1 l=0", d, f, l, exp);
    end
    exp = '0;
    exp[511:480] = 32'h8000_0000;
    exp[31:0]    = 32'h200;
    get_block(0, d, f, l);
    checks++;
    if (d !== exp || f !== 1'b0 || l !== 1'b1) begin
      errors++;
      $display("FAIL b64_blk2: got %h f=%0b l=%0b required %h f=0 l=1", d, f, l, exp);
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 7; i++) send_word(pat(i), 3'd4, 1'b0);
    @(negedge wb_clk_i);
    checks++;
    if (busy !== 1'b1 || blk_data[511:480] !== pat(0)) begin
      errors++;
      $display("FAIL mid_fill: busy=%0b w0=%h, required 1/%h", busy, blk_data[511:480], pat(0));
    end
    #2 wb_rst_i = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1 || blk_valid !== 1'b0 || busy !== 1'b0 || blk_data !== 512'd0) begin
      errors++;
      $display("FAIL mid_reset: in_ready=%0b valid=%0b busy=%0b data=%h, required 1/0/0/0",
               in_ready, blk_valid, busy, blk_data);
    end
    @(negedge wb_clk_i);
    wb_rst_i = 1'b0;
    test_abc();
  endtask

  initial begin
    wb_rst_i  = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    in_nbytes = 3'd4;
    blk_ready = 1'b0;
    test_reset();
    test_abc();
    test_empty();
    test_55_bytes();
    test_56_bytes();
    test_64_bytes_stall();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
